multi_entry_write_buffer: RTL and testbench
===========================================

MULTI_ENTRY_WRITE_BUFFER -- requirements
Module: multi_entry_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of buffered eviction lines, integer >= 2.
REQ-002 SHALL have parameter LINE_WIDTH, default 128: line data width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16: line address width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports mem_read, mem_write  input  1 each  upstream (L2-side) requests.
REQ-007 SHALL have port mem_address  input  ADDR_WIDTH  upstream line address.
REQ-008 SHALL have port mem_wdata  input  LINE_WIDTH  evicted line data.
REQ-009 SHALL have port mem_resp  output  1  upstream completion, one cycle per request.
REQ-010 SHALL have port mem_rdata  output  LINE_WIDTH  read data to upstream.
REQ-011 SHALL have ports pmem_read, pmem_write  output  1 each  physical-memory requests.
REQ-012 SHALL have port pmem_address  output  ADDR_WIDTH  physical-memory line address.
REQ-013 SHALL have port pmem_wdata  output  LINE_WIDTH  physical-memory write data.
REQ-014 SHALL have ports pmem_resp  input  1 and pmem_rdata  input  LINE_WIDTH  physical-memory completion and read data.
REQ-015 SHALL have ports full, empty  output  1 each  occupancy status (count==DEPTH, count==0).

Function
REQ-016 SHALL hold DEPTH entries {valid, address, data} as a circular FIFO with head/tail pointers wrapping modulo DEPTH and a count of width $clog2(DEPTH+1).
REQ-017 SHALL run FSM states IDLE, DRAIN, READ_THRU.
REQ-018 Write, address matching a valid non-draining entry: overwrite that entry's data in place (coalesce), count unchanged, mem_resp=1 same cycle.
REQ-019 Write, no match, not full: allocate at tail, count+1, mem_resp=1 same cycle.
REQ-020 Write when full, or matching the head entry while in DRAIN: mem_resp=0 (stall) until a slot frees or the drain completes; upstream holds the request.
REQ-021 Read hitting any valid entry: mem_rdata=entry data, mem_resp=1 same cycle, in any state, no pmem access.
REQ-022 Read miss in IDLE: go to READ_THRU; pmem_read=1, pmem_address=mem_address, mem_rdata=pmem_rdata, mem_resp=pmem_resp; return to IDLE the cycle after pmem_resp.
REQ-023 Read miss in DRAIN: mem_resp=0 until the drain completes, then serviced per REQ-022.
REQ-024 IDLE with no upstream request and empty=0: go to DRAIN next cycle.
REQ-025 DRAIN: pmem_write=1, pmem_address/pmem_wdata = head entry, held stable until pmem_resp; no abort.
REQ-026 On pmem_resp in DRAIN: invalidate head, head+1, count-1; go to IDLE.
REQ-027 Same-cycle allocate and drain-pop: count unchanged; full SHALL NOT deassert spuriously.
REQ-028 mem_read and mem_write asserted together: write serviced, read ignored that cycle.
REQ-029 pmem_read and pmem_write SHALL never be asserted together.
REQ-030 At most one valid entry per address at any time.

Reset
REQ-031 rst_n low SHALL asynchronously clear all valid bits, head, tail and count to 0 and set state to IDLE.
REQ-032 During reset: mem_resp, pmem_read, pmem_write = 0; empty=1; full=0; mem_rdata, pmem_address, pmem_wdata = 0.
REQ-033 Reset mid-DRAIN SHALL drop pmem_write immediately; buffered data is discarded.

Verification
REQ-034 DEPTH=4: write lines A=0x0010..D=0x0040, no pmem_resp -> mem_resp=1 each cycle, full=1 after 4th; 5th write 0x0050 stalls until first pmem_resp, then accepted.
REQ-035 Write 0x0010 data X, then 0x0010 data Y while idle -> count stays 1; drain issues pmem_write addr 0x0010 data Y exactly once.
REQ-036 Buffer holds 0x0020=Z; read 0x0020 -> mem_resp same cycle, mem_rdata=Z, pmem_read=0.
REQ-037 Drain of 0x0030 in progress, read miss 0x0100 -> mem_resp=0 until pmem_resp of the write, then pmem_read addr 0x0100 issued, mem_rdata=pmem_rdata.
REQ-038 Head and tail wrap: 10 write/drain pairs at DEPTH=4 -> FIFO order preserved on pmem, empty=1 at end.
REQ-039 Assert rst_n=0 mid-DRAIN -> pmem_write=0 without a clock edge; after release empty=1, state IDLE.

Source files
------------

// File: rtl/multi_entry_write_buffer.sv
// Write buffer between L2 and physical memory: queues evicted lines in a small
// FIFO, coalesces rewrites, serves read hits locally and drains when idle.
module multi_entry_write_buffer #(
  parameter int DEPTH      = 4,
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [LINE_WIDTH-1:0] mem_wdata,
  output logic                  mem_resp,
  output logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, READ_THRU} state_t;

  state_t                  state_reg, state_next;
  logic [DEPTH-1:0]        valid_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg [DEPTH];
  logic [LINE_WIDTH-1:0]   data_reg [DEPTH];
  logic [PTR_W-1:0]        head_reg, tail_reg;
  logic [CNT_W-1:0]        count_reg;

  logic [DEPTH-1:0]        hit_vec, wr_match_vec;
  logic [PTR_W-1:0]        hit_idx, wr_idx;
  logic                    any_hit, wr_coalesce, wr_alloc, rd_hit, rd_miss, drain_pop;

  // The head entry is locked while it is on the pmem bus, so writes to it stall.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign hit_vec[gi]      = valid_reg[gi] && (addr_reg[gi] == mem_address);
    assign wr_match_vec[gi] = hit_vec[gi] &&
                              !(state_reg == DRAIN && head_reg == PTR_W'(gi));
  end

  always_comb begin
    hit_idx = '0;
    wr_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_vec[i])      hit_idx = PTR_W'(i);
      if (wr_match_vec[i]) wr_idx  = PTR_W'(i);
    end
  end

  assign full        = (count_reg == CNT_W'(DEPTH));
  assign empty       = (count_reg == '0);
  assign any_hit     = |hit_vec;
  assign wr_coalesce = rst_n && mem_write && (|wr_match_vec);
  assign wr_alloc    = rst_n && mem_write && !any_hit && !full;
  assign rd_hit      = mem_read && !mem_write && any_hit;
  assign rd_miss     = mem_read && !mem_write && !any_hit;
  assign drain_pop   = (state_reg == DRAIN) && pmem_resp;

  always_comb begin
    state_next   = state_reg;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    if (rst_n) begin
      if (mem_write) begin
        mem_resp = wr_coalesce || wr_alloc;
      end else if (rd_hit) begin
        mem_resp  = 1'b1;
        mem_rdata = data_reg[hit_idx];
      end
      case (state_reg)
        IDLE: begin
          // A stalled write also counts as "no progress", so a full buffer drains.
          if (rd_miss)                 state_next = READ_THRU;
          else if (!mem_resp && !empty) state_next = DRAIN;
        end
        DRAIN: begin
          pmem_write   = 1'b1;
          pmem_address = addr_reg[head_reg];
          pmem_wdata   = data_reg[head_reg];
          if (pmem_resp) state_next = IDLE;
        end
        READ_THRU: begin
          pmem_read    = 1'b1;
          pmem_address = mem_address;
          if (rd_miss) begin
            mem_resp  = pmem_resp;
            mem_rdata = pmem_rdata;
          end
          if (pmem_resp) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (drain_pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg <= (head_reg == PTR_W'(DEPTH - 1)) ? '0 : head_reg + PTR_W'(1);
      end
      if (wr_alloc) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg <= (tail_reg == PTR_W'(DEPTH - 1)) ? '0 : tail_reg + PTR_W'(1);
      end
      case ({wr_alloc, drain_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Line storage carries no reset; validity alone decides what is live.
  always_ff @(posedge clk) begin
    if (wr_alloc) begin
      addr_reg[tail_reg] <= mem_address;
      data_reg[tail_reg] <= mem_wdata;
    end
    if (wr_coalesce) data_reg[wr_idx] <= mem_wdata;
  end

endmodule

// File: tb/tb_multi_entry_write_buffer.sv
// Self-checking bench: vector table for fill/stall/hit behaviour, hand sequences
// for drain, read-through, wrap and reset, and a pmem model with drain scoreboard.
module tb_multi_entry_write_buffer;
  localparam int DEPTH = 4;
  localparam int LW    = 128;
  localparam int AW    = 16;
  localparam int LAT   = 2;

  logic          clk, rst_n;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic          mem_resp;
  logic [LW-1:0] mem_rdata;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;
  logic          full, empty;

  multi_entry_write_buffer #(.DEPTH(DEPTH), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .full(full), .empty(empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical memory read data is a pure function of the address.
  assign pmem_rdata = {8{pmem_address}};

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [LW-1:0] d;
  } wr_t;
  wr_t exp_q[$];

  logic pmem_hold;
  int   busy_cnt;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic logic [LW-1:0] ln(input logic [AW-1:0] a, input logic [7:0] t);
    return {t, 104'h0, a};
  endfunction

  // pmem model: answers LAT cycles after a request appears, checks drain order.
  initial begin
    pmem_resp = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!rst_n || !(pmem_read || pmem_write)) begin
        busy_cnt = 0;
      end else begin
        if (pmem_read && pmem_write)
          check("pmem_rw_exclusive", {pmem_read, pmem_write}, 2'b01);
        if (!pmem_hold) begin
          if (busy_cnt == LAT) begin
            pmem_resp = 1'b1;
            busy_cnt  = 0;
            if (pmem_write) begin
              if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL drain_unexpected: got pmem write addr %0h, required none", pmem_address);
              end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("drain_addr", pmem_address, e.a);
                check("drain_data", pmem_wdata, e.d);
              end
            end
          end else begin
            busy_cnt++;
          end
        end
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
    @(negedge clk);
    mem_read = r; mem_write = w; mem_address = a; mem_wdata = d;
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [LW-1:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drained(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      drive(1'b0, 1'b0, '0, '0);
      if (exp_q.size() == 0 && empty && !pmem_write) done = 1'b1;
    end
    check(name, done, 1'b1);
  endtask

  typedef struct {
    logic          rd, wr;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    logic [1:0]    sb;    // 1: new drain expected, 2: updates a queued line
    logic          resp;
    logic [LW-1:0] rdata;
    logic          full, empty, pw;
  } vec_t;

  function automatic vec_t v(input logic rd, input logic wr, input logic [AW-1:0] a,
                             input logic [LW-1:0] d, input logic [1:0] sb, input logic resp,
                             input logic [LW-1:0] rdata, input logic fu, input logic em,
                             input logic pw);
    vec_t x;
    x.rd = rd; x.wr = wr; x.a = a; x.d = d; x.sb = sb; x.resp = resp;
    x.rdata = rdata; x.full = fu; x.empty = em; x.pw = pw;
    return x;
  endfunction

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    logic          got, saw_pread;
    int            stall;
    logic [LW-1:0] q_data;

    rst_n = 1'b0; pmem_hold = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;

    // Fill / hit / stall table; pmem held off so the drain cannot complete.
    vecs[0]  = v(0, 1, 16'h0010, ln(16'h0010, 8'hA0), 1, 1, '0, 0, 1, 0);
    vecs[1]  = v(0, 1, 16'h0020, ln(16'h0020, 8'hB0), 1, 1, '0, 0, 0, 0);
    vecs[2]  = v(0, 1, 16'h0030, ln(16'h0030, 8'hC0), 1, 1, '0, 0, 0, 0);
    vecs[3]  = v(0, 1, 16'h0040, ln(16'h0040, 8'hD0), 1, 1, '0, 0, 0, 0);
    vecs[4]  = v(1, 0, 16'h0020, '0, 0, 1, ln(16'h0020, 8'hB0), 1, 0, 0);
    vecs[5]  = v(0, 1, 16'h0020, ln(16'h0020, 8'hB2), 2, 1, '0, 1, 0, 0);
    vecs[6]  = v(0, 1, 16'h0050, ln(16'h0050, 8'hE0), 0, 0, '0, 1, 0, 0);
    vecs[7]  = v(0, 1, 16'h0050, ln(16'h0050, 8'hE0), 0, 0, '0, 1, 0, 1);
    vecs[8]  = v(1, 0, 16'h0010, '0, 0, 1, ln(16'h0010, 8'hA0), 1, 0, 1);
    vecs[9]  = v(0, 1, 16'h0010, ln(16'h0010, 8'hA2), 0, 0, '0, 1, 0, 1);
    vecs[10] = v(1, 0, 16'h0070, '0, 0, 0, '0, 1, 0, 1);
    vecs[11] = v(1, 1, 16'h0030, ln(16'h0030, 8'hC2), 2, 1, '0, 1, 0, 1);

    // Reset values, including a write attempted while reset is held.
    #1;
    check("rst_mem_resp", mem_resp, 1'b0);
    check("rst_pmem_rw", {pmem_read, pmem_write}, 2'b00);
    check("rst_empty_full", {empty, full}, 2'b10);
    check("rst_buses", {mem_rdata, pmem_address, pmem_wdata}, '0);
    mem_write = 1'b1; mem_address = 16'h0010;
    #1;
    check("rst_write_ignored", mem_resp, 1'b0);
    mem_write = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    pmem_hold = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d);
      check($sformatf("v%0d_resp", i), mem_resp, vecs[i].resp);
      check($sformatf("v%0d_full_empty", i), {full, empty}, {vecs[i].full, vecs[i].empty});
      check($sformatf("v%0d_pmem", i), {pmem_read, pmem_write}, {1'b0, vecs[i].pw});
      if (vecs[i].rd && !vecs[i].wr && vecs[i].resp)
        check($sformatf("v%0d_rdata", i), mem_rdata, vecs[i].rdata);
      if (vecs[i].sb == 2'd1) push(vecs[i].a, vecs[i].d);
      else if (vecs[i].sb == 2'd2)
        foreach (exp_q[k]) if (exp_q[k].a == vecs[i].a) exp_q[k].d = vecs[i].d;
    end

    // Held write to 0x0050 is accepted only after the first drain completes.
    pmem_hold = 1'b0;
    got = 1'b0; stall = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      drive(1'b0, 1'b1, 16'h0050, ln(16'h0050, 8'hE0));
      if (mem_resp) got = 1'b1;
      else stall++;
    end
    check("full_write_accepted", got, 1'b1);
    check("full_write_after_pop", exp_q.size(), 3);
    check("full_write_stalled", stall >= LAT + 1, 1'b1);
    push(16'h0050, ln(16'h0050, 8'hE0));
    wait_drained("fill_drained");

    // Back-to-back rewrite of one line coalesces into a single drain.
    drive(0, 1, 16'h0010, ln(16'h0010, 8'h11));
    check("coal_first_resp", mem_resp, 1'b1);
    drive(0, 1, 16'h0010, ln(16'h0010, 8'h22));
    check("coal_second_resp", mem_resp, 1'b1);
    push(16'h0010, ln(16'h0010, 8'h22));
    wait_drained("coal_drained");

    // Read hit is answered locally in the same cycle.
    drive(0, 1, 16'h0020, ln(16'h0020, 8'h5A));
    push(16'h0020, ln(16'h0020, 8'h5A));
    drive(1, 0, 16'h0020, '0);
    check("hit_resp", mem_resp, 1'b1);
    check("hit_rdata", mem_rdata, ln(16'h0020, 8'h5A));
    check("hit_no_pmem_read", pmem_read, 1'b0);
    wait_drained("hit_drained");

    // Read miss during a drain waits for the write, then reads through.
    q_data = ln(16'h0030, 8'h33);
    drive(0, 1, 16'h0030, q_data);
    push(16'h0030, q_data);
    pmem_hold = 1'b1;
    drive(0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 16'h0100, '0);
      check("miss_in_drain_stall", {mem_resp, pmem_read, pmem_write}, 3'b001);
    end
    pmem_hold = 1'b0;
    got = 1'b0; saw_pread = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      drive(1, 0, 16'h0100, '0);
      if (pmem_read) begin
        saw_pread = 1'b1;
        check("rt_pmem_addr", pmem_address, 16'h0100);
      end
      if (mem_resp) got = 1'b1;
    end
    check("rt_resp", got, 1'b1);
    check("rt_rdata", mem_rdata, {8{16'h0100}});
    check("rt_write_first", exp_q.size(), 0);
    check("rt_pmem_read_seen", saw_pread, 1'b1);
    wait_drained("rt_drained");

    // Allocate in the very cycle the drain pops: count must stay at one.
    drive(0, 1, 16'h0200, ln(16'h0200, 8'h20));
    push(16'h0200, ln(16'h0200, 8'h20));
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      drive(0, 0, '0, '0);
      if (pmem_write) got = 1'b1;
    end
    check("sc_drain_started", got, 1'b1);
    drive(0, 0, '0, '0);
    drive(0, 1, 16'h0210, ln(16'h0210, 8'h21));
    check("sc_pop_and_alloc", {pmem_resp, mem_resp}, 2'b11);
    push(16'h0210, ln(16'h0210, 8'h21));
    drive(0, 0, '0, '0);
    check("sc_count_kept", {full, empty}, 2'b00);
    wait_drained("sc_drained");

    // Ten write/drain pairs walk head and tail around the ring.
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 16'h0400 + AW'(i * 16), ln(16'h0400 + AW'(i * 16), 8'(i)));
      check($sformatf("wrap%0d_resp", i), mem_resp, 1'b1);
      push(16'h0400 + AW'(i * 16), ln(16'h0400 + AW'(i * 16), 8'(i)));
      wait_drained($sformatf("wrap%0d_drained", i));
    end
    check("wrap_empty", empty, 1'b1);

    // Reset in the middle of a drain drops pmem_write without a clock edge.
    pmem_hold = 1'b1;
    drive(0, 1, 16'h0300, ln(16'h0300, 8'h30));
    drive(0, 0, '0, '0);
    drive(0, 0, '0, '0);
    check("mid_drain_active", pmem_write, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pmem_write", pmem_write, 1'b0);
    check("async_rst_empty", {empty, full}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    pmem_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, '0);
      check("post_rst_idle", {pmem_read, pmem_write, empty}, 3'b001);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

endmodule
